// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state enum and default parameters for clk_div_monitor
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    LOST = 2'd2
  } mon_state_e;

  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned TIMEOUT_DEF     = 32'd1000000;
  localparam int unsigned LOCK_CNT_DEF    = 4;
  localparam int unsigned TOL_DEF         = 0;

endpackage

// File: rtl/clk_edge_sync.sv
// rtl/clk_edge_sync.sv - synchronizer chain plus previous-value register, emits rise/fall strobes
module clk_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - period/high-time measurement, lock and loss detection of a slow clock
// High-time logic is built only when CLK_DIV_MON_DUTY_EN is defined; otherwise high_o is 0.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
  parameter int unsigned TOL         = TOL_DEF
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             lost_o
);

  localparam int unsigned       MW       = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]     LOCK_MAX = MW'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]    TOL_W    = (CNT_W + 1)'(TOL);

  logic rise;
  logic fall;

  clk_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk_i (clk_i),
    .rst   (rst),
    .sig_i (clk_in),
    .rise_o(rise),
    .fall_o(fall)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [MW-1:0]    match_q, match_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;

  // meas is the length ending at this cycle; a saturated counter reports all-ones.
  logic [CNT_W-1:0] meas;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   abs_diff;
  logic             timeout;
  logic             match;

  assign meas     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign cnt_d    = rise ? '0 : meas;
  assign timeout  = (cnt_q == TO_LAST);
  assign diff     = {1'b0, meas} - {1'b0, period_q};
  assign abs_diff = diff[CNT_W] ? (~diff + 1'b1) : diff;
  assign match    = (abs_diff <= TOL_W);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    match_d  = match_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
        end else if (timeout) begin
          state_d  = LOST;
          match_d  = '0;
          locked_d = 1'b0;
        end
      end
      MEAS: begin
        if (rise) begin
          valid_d  = 1'b1;
          period_d = meas;
          if (match) begin
            if (match_q != LOCK_MAX) begin
              match_d = match_q + 1'b1;
            end
            locked_d = (match_d == LOCK_MAX);
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
          end
        end else if (timeout) begin
          state_d  = LOST;
          match_d  = '0;
          locked_d = 1'b0;
        end
      end
      LOST: begin
        match_d  = '0;
        locked_d = 1'b0;
        if (rise) begin
          state_d = MEAS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

`ifdef CLK_DIV_MON_DUTY_EN
  logic [CNT_W-1:0] high_q;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      high_q <= '0;
    end else if (state_q == MEAS && fall) begin
      high_q <= meas;
    end
  end

  assign high_o = high_q;
`else
  logic unused_fall;
  assign unused_fall = fall;
  assign high_o      = '0;
`endif

  assign period_o = period_q;
  assign valid_o  = valid_q;
  assign locked_o = locked_q;
  assign lost_o   = (state_q == LOST);

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed self-checking bench for clk_div_monitor (TOL=0 and TOL=1 instances)
module tb_clk_div_monitor;

`ifdef CLK_DIV_MON_DUTY_EN
  localparam int H5 = 5;
  localparam int H6 = 6;
`else
  localparam int H5 = 0;
  localparam int H6 = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        clk_in = 1'b0;
  logic [31:0] period_a, high_a, period_b, high_b;
  logic        valid_a, locked_a, lost_a;
  logic        valid_b, locked_b, lost_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  clk_div_monitor #(
    .CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(50), .LOCK_CNT(4), .TOL(0)
  ) dut_a (
    .clk_i(clk_i), .rst(rst), .clk_in(clk_in),
    .period_o(period_a), .high_o(high_a), .valid_o(valid_a),
    .locked_o(locked_a), .lost_o(lost_a)
  );

  clk_div_monitor #(
    .CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(50), .LOCK_CNT(4), .TOL(1)
  ) dut_b (
    .clk_i(clk_i), .rst(rst), .clk_in(clk_in),
    .period_o(period_b), .high_o(high_b), .valid_o(valid_b),
    .locked_o(locked_b), .lost_o(lost_b)
  );

  // Valid-pulse log, sampled on the falling edge.
  int          cyc = 0;
  int          per_q[$];
  int          perb_q[$];
  int          hi_q[$];
  bit          lka_q[$];
  bit          lkb_q[$];
  int          last_valid_cyc = -1;
  int          lost_cyc_a = -1;
  int          lost_cyc_b = -1;
  int          b2b = 0;
  logic        valid_prev = 1'b0;
  logic        lost_a_prev = 1'b0;
  logic        lost_b_prev = 1'b0;

  always @(negedge clk_i) begin
    cyc = cyc + 1;
    if (valid_a) begin
      per_q.push_back(int'(period_a));
      hi_q.push_back(int'(high_a));
      lka_q.push_back(locked_a);
      last_valid_cyc = cyc;
    end
    if (valid_b) begin
      perb_q.push_back(int'(period_b));
      lkb_q.push_back(locked_b);
    end
    if (valid_a && valid_prev) b2b = b2b + 1;
    valid_prev = valid_a;
    if (lost_a && !lost_a_prev) lost_cyc_a = cyc;
    if (lost_b && !lost_b_prev) lost_cyc_b = cyc;
    lost_a_prev = lost_a;
    lost_b_prev = lost_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic drive(input logic lvl, input int n);
    clk_in = lvl;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    per_q.delete();
    perb_q.delete();
    hi_q.delete();
    lka_q.delete();
    lkb_q.delete();
  endtask

  task automatic test_reset();
    checks++; if (period_a !== 32'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", period_a); end
    checks++; if (high_a !== 32'd0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_a); end
    checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b exp 0", locked_a); end
    checks++; if (lost_a !== 1'b0) begin errors++; $display("FAIL reset_lost got %0b exp 0", lost_a); end
    checks++; if ({period_b, high_b, valid_b, locked_b, lost_b} !== '0) begin
      errors++; $display("FAIL reset_b got %0d/%0d exp 0/0", period_b, high_b);
    end
  endtask

  task automatic test_div10();
    clear_log();
    for (int i = 0; i < 12; i++) begin drive(1'b1, 5); drive(1'b0, 5); end
    checks++; if (per_q.size() !== 11) begin errors++; $display("FAIL div10_count got %0d exp 11", per_q.size()); end
    for (int i = 0; i < per_q.size(); i++) begin
      checks++; if (per_q[i] !== 10) begin errors++; $display("FAIL div10_period[%0d] got %0d exp 10", i, per_q[i]); end
      checks++; if (hi_q[i] !== H5) begin errors++; $display("FAIL div10_high[%0d] got %0d exp %0d", i, hi_q[i], H5); end
      checks++; if (lka_q[i] !== (i >= 4)) begin errors++; $display("FAIL div10_locked[%0d] got %0b exp %0b", i, lka_q[i], (i >= 4)); end
      checks++; if (lkb_q[i] !== (i >= 4)) begin errors++; $display("FAIL div10_locked_b[%0d] got %0b exp %0b", i, lkb_q[i], (i >= 4)); end
    end
  endtask

  task automatic test_period_step();
    int exp_p[6] = '{10, 12, 12, 12, 12, 12};
    bit exp_l[6] = '{1, 0, 0, 0, 0, 1};
    clear_log();
    for (int i = 0; i < 6; i++) begin drive(1'b1, 6); drive(1'b0, 6); end
    checks++; if (per_q.size() !== 6) begin errors++; $display("FAIL step_count got %0d exp 6", per_q.size()); end
    for (int i = 0; i < per_q.size() && i < 6; i++) begin
      checks++; if (per_q[i] !== exp_p[i]) begin errors++; $display("FAIL step_period[%0d] got %0d exp %0d", i, per_q[i], exp_p[i]); end
      checks++; if (lka_q[i] !== exp_l[i]) begin errors++; $display("FAIL step_locked[%0d] got %0b exp %0b", i, lka_q[i], exp_l[i]); end
      if (i >= 1) begin
        checks++; if (hi_q[i] !== H6) begin errors++; $display("FAIL step_high[%0d] got %0d exp %0d", i, hi_q[i], H6); end
      end
    end
  endtask

  task automatic test_tolerance();
    int exp_p[8]  = '{12, 10, 11, 10, 11, 10, 11, 10};
    bit exp_la[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit exp_lb[8] = '{1, 0, 0, 0, 0, 1, 1, 1};
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5); drive(1'b0, 5);
      drive(1'b1, 5); drive(1'b0, 6);
    end
    checks++; if (lkb_q.size() !== 8) begin errors++; $display("FAIL tol_count got %0d exp 8", lkb_q.size()); end
    for (int i = 0; i < lkb_q.size() && i < 8; i++) begin
      checks++; if (per_q[i] !== exp_p[i]) begin errors++; $display("FAIL tol_period[%0d] got %0d exp %0d", i, per_q[i], exp_p[i]); end
      checks++; if (perb_q[i] !== exp_p[i]) begin errors++; $display("FAIL tol_period_b[%0d] got %0d exp %0d", i, perb_q[i], exp_p[i]); end
      checks++; if (lka_q[i] !== exp_la[i]) begin errors++; $display("FAIL tol0_locked[%0d] got %0b exp %0b", i, lka_q[i], exp_la[i]); end
      checks++; if (lkb_q[i] !== exp_lb[i]) begin errors++; $display("FAIL tol1_locked[%0d] got %0b exp %0b", i, lkb_q[i], exp_lb[i]); end
    end
  endtask

  task automatic test_timeout_edge();
    clear_log();
    drive(1'b1, 25); drive(1'b0, 25);
    drive(1'b1, 25); drive(1'b0, 25);
    checks++; if (per_q.size() !== 2) begin errors++; $display("FAIL edge_count got %0d exp 2", per_q.size()); end
    if (per_q.size() == 2) begin
      checks++; if (per_q[1] !== 50) begin errors++; $display("FAIL edge_period got %0d exp 50", per_q[1]); end
    end
    checks++; if (lost_cyc_a !== -1) begin errors++; $display("FAIL edge_no_loss got cycle %0d exp -1", lost_cyc_a); end
  endtask

  task automatic test_loss_recovery();
    drive(1'b0, 70);
    checks++; if (lost_a !== 1'b1) begin errors++; $display("FAIL loss_lost got %0b exp 1", lost_a); end
    checks++; if (lost_cyc_a - last_valid_cyc !== 50) begin
      errors++; $display("FAIL loss_delay got %0d exp 50", lost_cyc_a - last_valid_cyc);
    end
    checks++; if (lost_cyc_b !== lost_cyc_a) begin errors++; $display("FAIL loss_delay_b got %0d exp %0d", lost_cyc_b, lost_cyc_a); end
    checks++; if (locked_a !== 1'b0 || locked_b !== 1'b0) begin
      errors++; $display("FAIL loss_locked got %0b%0b exp 00", locked_a, locked_b);
    end
    clear_log();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 5); drive(1'b0, 5); end
    checks++; if (per_q.size() !== 2) begin errors++; $display("FAIL recover_count got %0d exp 2", per_q.size()); end
    for (int i = 0; i < per_q.size() && i < 2; i++) begin
      checks++; if (per_q[i] !== 10) begin errors++; $display("FAIL recover_period[%0d] got %0d exp 10", i, per_q[i]); end
    end
    checks++; if (lost_a !== 1'b0) begin errors++; $display("FAIL recover_lost got %0b exp 0", lost_a); end
    checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL recover_locked got %0b exp 0", locked_a); end
  endtask

  task automatic test_reset_mid();
    bit exp_l[5] = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin drive(1'b1, 5); drive(1'b0, 5); end
    checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL premid_locked got %0b exp 1", locked_a); end
    drive(1'b1, 2);
    rst = 1'b1;
    @(posedge clk_i);
    #1;
    rst    = 1'b0;
    clk_in = 1'b0;
    checks++; if ({period_a, high_a, valid_a, locked_a, lost_a} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got p=%0d h=%0d v=%0b l=%0b x=%0b exp all 0",
                         period_a, high_a, valid_a, locked_a, lost_a);
    end
    clear_log();
    drive(1'b0, 5);
    for (int i = 0; i < 6; i++) begin drive(1'b1, 5); drive(1'b0, 5); end
    checks++; if (per_q.size() !== 5) begin errors++; $display("FAIL mid_count got %0d exp 5", per_q.size()); end
    for (int i = 0; i < per_q.size() && i < 5; i++) begin
      checks++; if (per_q[i] !== 10) begin errors++; $display("FAIL mid_period[%0d] got %0d exp 10", i, per_q[i]); end
      checks++; if (hi_q[i] !== H5) begin errors++; $display("FAIL mid_high[%0d] got %0d exp %0d", i, hi_q[i], H5); end
      checks++; if (lka_q[i] !== exp_l[i]) begin errors++; $display("FAIL mid_locked[%0d] got %0b exp %0b", i, lka_q[i], exp_l[i]); end
    end
  endtask

  task automatic test_back_to_back();
    checks++; if (b2b !== 0) begin errors++; $display("FAIL valid_back_to_back got %0d exp 0", b2b); end
  endtask

  initial begin
    rst    = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst = 1'b0;
    test_reset();
    test_div10();
    test_period_step();
    test_tolerance();
    test_timeout_edge();
    test_loss_recovery();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
